// File: rtl/dostring_seq.sv
// dostring_seq: frame sequencer for a single doled LED-output engine.
//
// Each frame is one wand column: a START record, STRING_SIZE LED records and
// an END record, then FRAME_GAP idle cycles. Columns advance 0..NUMBER_STRINGS-1
// and wrap, forming one sweep. Per-LED colours come from a pattern source over
// a level pix_req / pix_valid handshake.
//
// Ports:
//   dostring_seq_clk    clock
//   dostring_seq_reset  synchronous active-high reset
//   enable              run frames while high (a started frame always completes)
//   pix_req/pix_index/pix_col   pixel request towards the pattern source
//   pix_valid, pix_blue/green/red   pixel response
//   led_blue/green/red, led_type, led_start   record to doled
//   led_busy            doled busy
//   frame_done          pulse when END completes
//   sweep_done          pulse when END of the last column completes
//   busy                high in every state except IDLE
//
// Build option: define DOSTRING_SEQ_CLAMP_EN to clamp each latched colour
// channel to MAX_COLOR_VALUE. Default build latches colours unmodified.

module dostring_seq #(
  parameter int STRING_SIZE     = 47,
  parameter int NUMBER_STRINGS  = 47,
  parameter int FRAME_GAP       = 1000,
  parameter int MAX_COLOR_VALUE = 100
) (
  input  logic       dostring_seq_clk,
  input  logic       dostring_seq_reset,
  input  logic       enable,
  output logic       pix_req,
  output logic [7:0] pix_index,
  output logic [7:0] pix_col,
  input  logic       pix_valid,
  input  logic [7:0] pix_blue,
  input  logic [7:0] pix_green,
  input  logic [7:0] pix_red,
  output logic [7:0] led_blue,
  output logic [7:0] led_green,
  output logic [7:0] led_red,
  output logic [1:0] led_type,
  output logic       led_start,
  input  logic       led_busy,
  output logic       frame_done,
  output logic       sweep_done,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_GUARD,
    S_WAIT,
    S_FETCH,
    S_GAP
  } state_t;

  localparam logic [1:0]  T_START   = 2'd0;
  localparam logic [1:0]  T_LED     = 2'd1;
  localparam logic [1:0]  T_END     = 2'd2;
  localparam logic [7:0]  LAST_IDX  = 8'(STRING_SIZE - 1);
  localparam logic [7:0]  LAST_COL  = 8'(NUMBER_STRINGS - 1);
  localparam logic [15:0] GAP_LOAD  = 16'(FRAME_GAP);
  localparam logic [7:0]  CLAMP_MAX = 8'(MAX_COLOR_VALUE);

`ifdef DOSTRING_SEQ_CLAMP_EN
  localparam bit CLAMP_ON = 1'b1;
`else
  localparam bit CLAMP_ON = 1'b0;
`endif

  function automatic logic [7:0] sat_chan(input logic [7:0] x);
    if (CLAMP_ON && (x > CLAMP_MAX)) return CLAMP_MAX;
    return x;
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  col_q, col_d;
  logic [15:0] gap_q, gap_d;
  logic [1:0]  type_q, type_d;
  logic [7:0]  blue_q, blue_d;
  logic [7:0]  green_q, green_d;
  logic [7:0]  red_q, red_d;

  always_ff @(posedge dostring_seq_clk) begin
    if (dostring_seq_reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      col_q   <= '0;
      gap_q   <= '0;
      type_q  <= T_START;
      blue_q  <= '0;
      green_q <= '0;
      red_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      col_q   <= col_d;
      gap_q   <= gap_d;
      type_q  <= type_d;
      blue_q  <= blue_d;
      green_q <= green_d;
      red_q   <= red_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    col_d      = col_q;
    gap_d      = gap_q;
    type_d     = type_q;
    blue_d     = blue_q;
    green_d    = green_q;
    red_d      = red_q;
    led_start  = 1'b0;
    pix_req    = 1'b0;
    frame_done = 1'b0;
    sweep_done = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          type_d  = T_START;
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (!led_busy) begin
          led_start = 1'b1;
          state_d   = S_GUARD;
        end
      end

      // doled raises busy only the cycle after start, so busy is not trusted here.
      S_GUARD: begin
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (!led_busy) begin
          case (type_q)
            T_START: begin
              idx_d   = '0;
              state_d = S_FETCH;
            end
            T_LED: begin
              if (idx_q < LAST_IDX) begin
                idx_d   = idx_q + 8'd1;
                state_d = S_FETCH;
              end else begin
                type_d  = T_END;
                state_d = S_ISSUE;
              end
            end
            default: begin
              frame_done = 1'b1;
              if (col_q == LAST_COL) begin
                col_d      = '0;
                sweep_done = 1'b1;
              end else begin
                col_d = col_q + 8'd1;
              end
              gap_d   = GAP_LOAD;
              state_d = S_GAP;
            end
          endcase
        end
      end

      S_FETCH: begin
        pix_req = 1'b1;
        if (pix_valid) begin
          blue_d  = sat_chan(pix_blue);
          green_d = sat_chan(pix_green);
          red_d   = sat_chan(pix_red);
          type_d  = T_LED;
          state_d = S_ISSUE;
        end
      end

      // A loaded value of 0 or 1 both leave after a single gap cycle.
      S_GAP: begin
        if (gap_q <= 16'd1) begin
          gap_d = '0;
          if (enable) begin
            type_d  = T_START;
            state_d = S_ISSUE;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          gap_d = gap_q - 16'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Reset overrides the combinational pulses in the very cycle it is asserted.
    if (dostring_seq_reset) begin
      led_start  = 1'b0;
      pix_req    = 1'b0;
      frame_done = 1'b0;
      sweep_done = 1'b0;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign pix_index = idx_q;
  assign pix_col   = col_q;
  assign led_type  = type_q;
  assign led_blue  = blue_q;
  assign led_green = green_q;
  assign led_red   = red_q;

endmodule

// File: tb/tb_dostring_seq.sv
// Directed testbench for dostring_seq with a doled busy model and a pattern
// source model. STRING_SIZE=3, NUMBER_STRINGS=2, FRAME_GAP=2.
module tb_dostring_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       pix_req;
  logic [7:0] pix_index;
  logic [7:0] pix_col;
  logic       pix_valid = 1'b0;
  logic [7:0] pix_blue = 8'd0;
  logic [7:0] pix_green = 8'd0;
  logic [7:0] pix_red = 8'd0;
  logic [7:0] led_blue, led_green, led_red;
  logic [1:0] led_type;
  logic       led_start;
  logic       led_busy;
  logic       frame_done, sweep_done, busy;

  dostring_seq #(
    .STRING_SIZE    (3),
    .NUMBER_STRINGS (2),
    .FRAME_GAP      (2),
    .MAX_COLOR_VALUE(100)
  ) dut (
    .dostring_seq_clk  (clk),
    .dostring_seq_reset(rst),
    .enable            (enable),
    .pix_req           (pix_req),
    .pix_index         (pix_index),
    .pix_col           (pix_col),
    .pix_valid         (pix_valid),
    .pix_blue          (pix_blue),
    .pix_green         (pix_green),
    .pix_red           (pix_red),
    .led_blue          (led_blue),
    .led_green         (led_green),
    .led_red           (led_red),
    .led_type          (led_type),
    .led_start         (led_start),
    .led_busy          (led_busy),
    .frame_done        (frame_done),
    .sweep_done        (sweep_done),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // doled model: busy for 4 cycles following each start
  int dl_cnt = 0;
  always @(posedge clk) begin
    if (led_start) dl_cnt <= 4;
    else if (dl_cnt != 0) dl_cnt <= dl_cnt - 1;
  end
  assign led_busy = (dl_cnt != 0);

  // pattern source: valid one cycle after req, extra stall for index 1
  int stall_len = 0;
  int src_wait  = 0;
  bit special   = 1'b0;
  always @(posedge clk) begin
    if (pix_req && !pix_valid) begin
      if (src_wait >= ((pix_index == 8'd1) ? stall_len : 0)) begin
        pix_valid <= 1'b1;
        src_wait  <= 0;
        if (special) begin
          pix_blue  <= 8'd200;
          pix_green <= 8'd50;
          pix_red   <= 8'd101;
        end else begin
          pix_blue  <= 8'h10 + pix_index;
          pix_green <= 8'h20 + pix_index;
          pix_red   <= 8'h30 + pix_col;
        end
      end else begin
        src_wait <= src_wait + 1;
      end
    end else begin
      pix_valid <= 1'b0;
      src_wait  <= 0;
    end
  end

  // record every doled start and done pulse
  int st_type[$], st_idx[$], st_col[$], st_blue[$], st_green[$], st_red[$], st_cyc[$];
  int fd_q[$], sd_q[$];
  always @(negedge clk) begin
    if (led_start) begin
      st_type.push_back(int'(led_type));
      st_idx.push_back(int'(pix_index));
      st_col.push_back(int'(pix_col));
      st_blue.push_back(int'(led_blue));
      st_green.push_back(int'(led_green));
      st_red.push_back(int'(led_red));
      st_cyc.push_back(cyc);
    end
    if (frame_done) fd_q.push_back(cyc);
    if (sweep_done) sd_q.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_fd(input int n, input int lim, input string tag);
    int k = 0;
    while (fd_q.size() < n && k < lim) begin
      step();
      k++;
    end
    if (fd_q.size() < n) chk(tag, fd_q.size(), n);
  endtask

  task automatic wait_led_start(input int idx, input int lim, input string tag);
    int k = 0;
    while (!(led_start && led_type == 2'd1 && (idx < 0 || int'(pix_index) == idx)) && k < lim) begin
      step();
      k++;
    end
    if (k >= lim) chk(tag, 32'(k), 32'(lim + 1));
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_type"}, led_type, 0);
    chk({pfx, "_col"}, pix_col, 0);
    chk({pfx, "_idx"}, pix_index, 0);
    chk({pfx, "_leds"}, {led_blue, led_green, led_red}, 0);
    chk({pfx, "_pulses"}, {led_start, pix_req, frame_done, sweep_done}, 0);
  endtask

  initial begin : main
    int exp_type[5] = '{0, 1, 1, 1, 2};
    int n_req, n_st, n_hold, n0, k, idle_cyc;

    // reset state
    rst = 1'b1;
    enable = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk_all_zero("rst");

    // frame 1, column 0
    enable = 1'b1;
    wait_fd(1, 200, "tmo_f1");
    chk("f1_nstart", st_type.size(), 5);
    if (st_type.size() >= 5) begin
      for (int i = 0; i < 5; i++) chk("f1_type", st_type[i], exp_type[i]);
      for (int i = 1; i < 4; i++) begin
        chk("f1_idx", st_idx[i], i - 1);
        chk("f1_rgb", {st_blue[i][7:0], st_green[i][7:0], st_red[i][7:0]},
            {8'h10 + 8'(i - 1), 8'h20 + 8'(i - 1), 8'h30});
      end
      chk("f1_col", st_col[0], 0);
    end
    chk("f1_sweep", sd_q.size(), 0);

    // next START three cycles after END completion
    k = 0;
    while (st_cyc.size() < 6 && k < 50) begin step(); k++; end
    if (st_cyc.size() >= 6 && fd_q.size() >= 1) chk("gap_start", st_cyc[5] - fd_q[0], 3);
    else chk("tmo_gap", st_cyc.size(), 6);

    // frame 2, column 1, sweep wraps
    wait_fd(2, 200, "tmo_f2");
    if (st_col.size() >= 6) chk("f2_col", st_col[5], 1);
    chk("sweep_n", sd_q.size(), 1);
    if (sd_q.size() >= 1 && fd_q.size() >= 2) chk("sweep_at", sd_q[0], fd_q[1]);
    step();
    chk("col_wrap", pix_col, 0);

    // frame 3: source stalls on index 1
    stall_len = 20;
    k = 0;
    while (!(pix_req && pix_index == 8'd1) && k < 200) begin step(); k++; end
    chk("stall_seen", pix_index, 1);
    n_req = 0; n_st = 0; n_hold = 0;
    for (int i = 0; i < 20; i++) begin
      if (pix_req) n_req++;
      if (led_start) n_st++;
      if (led_blue == 8'h10 && led_green == 8'h20 && led_red == 8'h30) n_hold++;
      step();
    end
    chk("stall_req", n_req, 20);
    chk("stall_start", n_st, 0);
    chk("stall_hold", n_hold, 20);
    wait_led_start(1, 50, "tmo_stall");
    chk("stall_rgb", {led_blue, led_green, led_red}, {8'h11, 8'h21, 8'h30});
    stall_len = 0;
    wait_fd(3, 300, "tmo_f3");

    // frame 4: enable dropped during LED index 1
    wait_led_start(1, 300, "tmo_f4");
    n0 = st_type.size();
    enable = 1'b0;
    wait_fd(4, 300, "tmo_f4_end");
    k = 0;
    while (busy && k < 50) begin step(); k++; end
    idle_cyc = cyc;
    chk("drop_busy", busy, 0);
    chk("drop_n", st_type.size() - n0, 2);
    if (st_type.size() >= n0 + 2) begin
      chk("drop_t0", st_type[n0], 1);
      chk("drop_i0", st_idx[n0], 2);
      chk("drop_t1", st_type[n0 + 1], 2);
    end
    if (fd_q.size() >= 4) chk("drop_idle", idle_cyc - fd_q[3], 3);
    chk("drop_sweep", sd_q.size(), 2);
    repeat (20) step();
    chk("no_restart", st_type.size() - n0, 2);

    // frame 5 completes, then reset in WAIT during frame 6
    enable = 1'b1;
    wait_fd(5, 300, "tmo_f5");
    wait_led_start(-1, 100, "tmo_f6");
    step();
    step();
    chk("pre_rst", {led_busy, busy, pix_col}, {1'b1, 1'b1, 8'd1});
    rst = 1'b1;
    step();
    chk_all_zero("rst2");
    rst = 1'b0;
    enable = 1'b0;
    n0 = st_type.size();
    repeat (20) step();
    chk("rst2_nostart", st_type.size() - n0, 0);
    chk("rst2_idle", busy, 0);

    // colour clamp option
    special = 1'b1;
    enable = 1'b1;
    wait_led_start(-1, 100, "tmo_clamp");
`ifdef DOSTRING_SEQ_CLAMP_EN
    chk("clamp_rgb", {led_blue, led_green, led_red}, {8'd100, 8'd50, 8'd100});
`else
    chk("clamp_rgb", {led_blue, led_green, led_red}, {8'd200, 8'd50, 8'd101});
`endif
    enable = 1'b0;
    repeat (5) step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
